// File: rtl/pll_lock_monitor.sv
// Lock supervisor for several PLLs: synchronises each raw lock bit, qualifies it
// with a settle timer, counts lock losses and shows U/A/L on one digit per channel.
module pll_lock_monitor #(
   parameter int NUM_CH        = 2,
   parameter int SETTLE_CYCLES = 1024,
   parameter int CNT_W         = 8,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_CH-1:0]         locked_in,
   input  logic                      clear_sticky,
   output logic [NUM_CH-1:0]         stable,
   output logic                      all_stable,
   output logic [NUM_CH-1:0]         lost_sticky,
   output logic [NUM_CH*CNT_W-1:0]   loss_count,
   output logic [NUM_CH*7-1:0]       hex
);

   localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [TW-1:0]    TIMER_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   localparam logic [6:0] SEG_U = 7'b1000001;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_L = 7'b1000111;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SETTLING = 2'd1,
      ST_LOCKED   = 2'd2
   } state_e;

   logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
   logic [NUM_CH-1:0] ls_s;
   logic [NUM_CH-1:0] loss_s;
   state_e            state_q [NUM_CH];
   logic [TW-1:0]     timer_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] sticky_q;
   logic [NUM_CH-1:0] sticky_d;

   // Plain flop chain per lock bit; nothing may sit between the stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= {NUM_CH{1'b0}};
      end else begin
         sync_q[0] <= locked_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign ls_s = sync_q[SYNC_STAGES-1];

   // Per-channel lock qualification FSM with settle timer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= ST_UNLOCKED;
            timer_q[i] <= {TW{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            case (state_q[i])
               ST_UNLOCKED: begin
                  if (ls_s[i]) begin
                     state_q[i] <= ST_SETTLING;
                     timer_q[i] <= {TW{1'b0}};
                  end
               end
               ST_SETTLING: begin
                  if (!ls_s[i]) begin
                     state_q[i] <= ST_UNLOCKED;
                  end else if (timer_q[i] == TIMER_LAST) begin
                     state_q[i] <= ST_LOCKED;
                  end else begin
                     timer_q[i] <= timer_q[i] + TW'(1);
                  end
               end
               ST_LOCKED: begin
                  if (!ls_s[i]) state_q[i] <= ST_UNLOCKED;
               end
               default: begin
                  state_q[i] <= ST_UNLOCKED;
                  timer_q[i] <= {TW{1'b0}};
               end
            endcase
         end
      end
   end

   // Loss bookkeeping: a clear lands first, so a loss on the same edge still counts.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         loss_s[i]   = (state_q[i] == ST_LOCKED) && !ls_s[i];
         cnt_d[i]    = clear_sticky ? {CNT_W{1'b0}} : cnt_q[i];
         sticky_d[i] = clear_sticky ? 1'b0 : sticky_q[i];
         if (loss_s[i]) begin
            sticky_d[i] = 1'b1;
            if (cnt_d[i] != CNT_MAX) begin
               cnt_d[i] = cnt_d[i] + CNT_W'(1);
            end else begin
               cnt_d[i] = CNT_MAX;
            end
         end else begin
            sticky_d[i] = sticky_d[i];
         end
      end
   end

   // Loss counter and sticky flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= {CNT_W{1'b0}};
         sticky_q <= {NUM_CH{1'b0}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
         sticky_q <= sticky_d;
      end
   end

   // Status and display decode straight from registered state.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         stable[i]                    = (state_q[i] == ST_LOCKED);
         loss_count[i*CNT_W +: CNT_W] = cnt_q[i];
         case (state_q[i])
            ST_UNLOCKED: hex[i*7 +: 7] = SEG_U;
            ST_SETTLING: hex[i*7 +: 7] = SEG_A;
            ST_LOCKED:   hex[i*7 +: 7] = SEG_L;
            default:     hex[i*7 +: 7] = SEG_U;
         endcase
      end
   end

   assign all_stable  = &stable;
   assign lost_sticky = sticky_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Random and directed stimulus for pll_lock_monitor, checked every cycle against a
// run-length reference model of the lock qualification rules.
module tb_pll_lock_monitor;

   localparam int NUM_CH = 2;
   localparam int SC     = 4;
   localparam int CNT_W  = 2;
   localparam int SS     = 2;
   localparam int CMAX   = (1 << CNT_W) - 1;

   localparam logic [6:0] U_SEG = 7'b1000001;
   localparam logic [6:0] A_SEG = 7'b0001000;
   localparam logic [6:0] L_SEG = 7'b1000111;

   logic                    clk = 1'b0;
   logic                    reset_n;
   logic [NUM_CH-1:0]       locked_in;
   logic                    clear_sticky;
   logic [NUM_CH-1:0]       stable;
   logic                    all_stable;
   logic [NUM_CH-1:0]       lost_sticky;
   logic [NUM_CH*CNT_W-1:0] loss_count;
   logic [NUM_CH*7-1:0]     hex;

   int n_vec = 0;
   int n_err = 0;

   // Model: input history for the synchroniser delay, and per channel the number of
   // consecutive edges that saw a high synchronised lock (capped at SC+1 = locked).
   logic [NUM_CH-1:0] hist [SS];
   int run    [NUM_CH];
   int cnt    [NUM_CH];
   bit sticky [NUM_CH];

   pll_lock_monitor #(
      .NUM_CH(NUM_CH), .SETTLE_CYCLES(SC), .CNT_W(CNT_W), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .locked_in(locked_in), .clear_sticky(clear_sticky),
      .stable(stable), .all_stable(all_stable), .lost_sticky(lost_sticky),
      .loss_count(loss_count), .hex(hex)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < SS; s++) hist[s] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         run[c] = 0; cnt[c] = 0; sticky[c] = 1'b0;
      end
   endtask

   task automatic model_edge();
      logic [NUM_CH-1:0] seen;
      bit was_locked;
      if (!reset_n) begin
         model_reset();
      end else begin
         seen = hist[SS-1];
         for (int s = SS-1; s > 0; s--) hist[s] = hist[s-1];
         hist[0] = locked_in;
         for (int c = 0; c < NUM_CH; c++) begin
            was_locked = (run[c] > SC);
            run[c] = seen[c] ? ((run[c] < SC+1) ? run[c] + 1 : SC+1) : 0;
            if (clear_sticky) begin
               cnt[c] = 0; sticky[c] = 1'b0;
            end
            if (was_locked && !seen[c]) begin
               sticky[c] = 1'b1;
               if (cnt[c] < CMAX) cnt[c]++;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [NUM_CH-1:0]       e_st, e_sticky;
      logic [NUM_CH*CNT_W-1:0] e_cnt;
      logic [NUM_CH*7-1:0]     e_hex;
      for (int c = 0; c < NUM_CH; c++) begin
         e_st[c]     = (run[c] > SC);
         e_sticky[c] = sticky[c];
         e_cnt[c*CNT_W +: CNT_W] = CNT_W'(cnt[c]);
         e_hex[c*7 +: 7] = (run[c] == 0) ? U_SEG : ((run[c] <= SC) ? A_SEG : L_SEG);
      end
      check_val("stable", 32'(stable), 32'(e_st));
      check_val("all_stable", 32'(all_stable), 32'(&e_st));
      check_val("lost_sticky", 32'(lost_sticky), 32'(e_sticky));
      check_val("loss_count", 32'(loss_count), 32'(e_cnt));
      check_val("hex", 32'(hex), 32'(e_hex));
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check_all();
      end
   endtask

   initial begin
      logic [CNT_W-1:0] sat_exp [5];
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
      sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

      reset_n = 1'b0; locked_in = '0; clear_sticky = 1'b0;
      model_reset();
      tick(3);
      check_val("reset_hex", 32'(hex), 32'({U_SEG, U_SEG}));
      reset_n = 1'b1;

      // Acquire on channel 0
      locked_in = 2'b01;
      tick(3);
      check_val("acq_hex0_A", 32'(hex[6:0]), 32'(A_SEG));
      tick(4);
      check_val("acq_stable0", 32'(stable[0]), 32'd1);
      check_val("acq_hex0_L", 32'(hex[6:0]), 32'(L_SEG));
      check_val("acq_hex1_U", 32'(hex[13:7]), 32'(U_SEG));
      check_val("acq_all_stable", 32'(all_stable), 32'd0);

      // Aborted settle on channel 1
      locked_in = 2'b11;
      tick(4);
      locked_in = 2'b01;
      tick(4);
      check_val("abort_hex1", 32'(hex[13:7]), 32'(U_SEG));
      check_val("abort_cnt1", 32'(loss_count[3:2]), 32'd0);
      check_val("abort_sticky1", 32'(lost_sticky[1]), 32'd0);

      // Repeated losses on channel 0 saturate the 2-bit counter
      for (int k = 0; k < 5; k++) begin
         locked_in[0] = 1'b0;
         tick(3);
         check_val("sat_cnt0", 32'(loss_count[1:0]), 32'(sat_exp[k]));
         locked_in[0] = 1'b1;
         tick(7);
      end
      check_val("sat_sticky0", 32'(lost_sticky[0]), 32'd1);

      // Clear on the same edge as a loss, then a clear on its own
      locked_in[0] = 1'b0;
      tick(2);
      clear_sticky = 1'b1;
      tick(1);
      clear_sticky = 1'b0;
      check_val("clrloss_cnt0", 32'(loss_count[1:0]), 32'd1);
      check_val("clrloss_sticky0", 32'(lost_sticky[0]), 32'd1);
      clear_sticky = 1'b1;
      tick(1);
      clear_sticky = 1'b0;
      check_val("clr_cnt0", 32'(loss_count[1:0]), 32'd0);
      check_val("clr_sticky0", 32'(lost_sticky[0]), 32'd0);

      // Reset while channel 0 settles with timer at 2
      locked_in = 2'b01;
      tick(5);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_val("rst_mid_hex0", 32'(hex[6:0]), 32'(U_SEG));
      check_val("rst_mid_stable", 32'(stable), 32'd0);
      tick(1);
      reset_n = 1'b1;
      tick(6);
      check_val("relock_early", 32'(stable[0]), 32'd0);
      tick(1);
      check_val("relock_on_time", 32'(stable[0]), 32'd1);

      // Random phase: slow toggling lock bits, occasional clears and resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < NUM_CH; c++)
            if ($urandom_range(0, 11) == 0) locked_in[c] = ~locked_in[c];
         clear_sticky = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 499) == 0) begin
            reset_n = 1'b0;
            #1;
            model_reset();
            check_all();
            tick(1);
            reset_n = 1'b1;
         end else begin
            tick(1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Parametrised lock supervisor for the clock-generation section of the top level. It accepts the raw `locked` outputs of up to several PLLs (the fixed PLL, the JTAG-reconfigurable PLL, and later additions) and synchronises each one into the `CLOCK_50` domain. Each channel is qualified with a settle timer so that a channel reports stable only after lock has held continuously. The block counts lock-loss events per channel, holds a sticky loss flag, and drives one seven-segment digit per channel showing U / A / L. This replaces the ad-hoc `locked ? L : U` HEX assignments.

## Interface
Parameters:
- `NUM_CH`, 2, number of monitored PLL channels (1..6).
- `SETTLE_CYCLES`, 1024, consecutive synchronised-high cycles required before a channel is declared locked (>=1).
- `CNT_W`, 8, width of each per-channel loss counter (>=1).
- `SYNC_STAGES`, 2, synchroniser depth on each `locked_in` bit (>=2).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  monitor clock (`CLOCK_50`).
- `reset_n`  in  1  asynchronous active-low reset; release is synchronous to `clk` at the top level.
- `locked_in`  in  NUM_CH  raw PLL lock outputs, asynchronous to `clk`; bit i = channel i.
- `clear_sticky`  in  1  synchronous, single-cycle; clears all `lost_sticky` bits and all loss counters.
- `stable`  out  NUM_CH  channel i is in LOCKED.
- `all_stable`  out  1  AND of all `stable` bits.
- `lost_sticky`  out  NUM_CH  channel i has dropped out of LOCKED since the last reset or clear.
- `loss_count`  out  NUM_CH*CNT_W  per-channel loss count; channel i occupies bits [i*CNT_W +: CNT_W].
- `hex`  out  NUM_CH*7  active-low segment code per channel (bit 0 = seg a); channel i occupies bits [i*7 +: 7].

## Operation
- **Synchroniser.** Each `locked_in[i]` passes through a `SYNC_STAGES`-flop chain. The last stage is `ls[i]`. No logic sits between the flops.
- **Per-channel FSM.** States are UNLOCKED, SETTLING and LOCKED. Each channel has a settle timer of width max(1, $clog2(SETTLE_CYCLES)).
  - UNLOCKED: if `ls`=1, go to SETTLING and set timer to 0. Otherwise stay.
  - SETTLING with `ls`=0: go to UNLOCKED. This is not a loss event; the counter and sticky flag are unchanged.
  - SETTLING with `ls`=1 and timer == SETTLE_CYCLES-1: go to LOCKED.
  - SETTLING with `ls`=1 otherwise: increment the timer.
  - LOCKED with `ls`=0: go to UNLOCKED. This is a loss event: `lost_sticky[i]` is set and `loss_count[i]` increments, saturating at 2^CNT_W-1 (never wraps).
- **Clear.** `clear_sticky`=1 sets every counter to 0 and every sticky bit to 0 on that edge.
- **Clear and loss in the same cycle.** Apply the clear first, then the loss: the counter becomes 1 and the sticky bit becomes 1.
- **Display.** Decode is combinational from state:
  - UNLOCKED = "U" = 7'b1000001.
  - SETTLING = "A" = 7'b0001000.
  - LOCKED = "L" = 7'b1000111.
- `stable[i]` is 1 exactly when channel i is in LOCKED. `all_stable` = &`stable`.
- Channels are fully independent; simultaneous events on several channels are each handled on the same edge.

## Timing
- **Reset (asynchronous assert).** Takes effect immediately:
  - all sync flops 0, all FSMs in UNLOCKED, timers 0;
  - `stable`=0, `all_stable`=0, `lost_sticky`=0, `loss_count`=0;
  - every `hex` digit = "U".
- **Reset mid-operation.** Discards any settle progress and all counts. There are no retained values.
- **Rise latency.** `locked_in` goes high before edge 1 and stays high:
  - `ls`=1 after edge SYNC_STAGES;
  - SETTLING after edge SYNC_STAGES+1;
  - `stable`=1 after edge SYNC_STAGES+1+SETTLE_CYCLES.
- **Fall latency.** `locked_in` goes low before edge 1: `stable` falls, and the counter and sticky update, after edge SYNC_STAGES+1.
- **Glitches.** A low glitch shorter than one `clk` period may be missed; this is acceptable. Any glitch captured into `ls` restarts settling.
- **Outputs.** All outputs are registered or decoded directly from registered state. There is no combinational path from `locked_in` or `clear_sticky` to any output.

## Test plan
- **Reset.** NUM_CH=2, SETTLE_CYCLES=4, SYNC_STAGES=2; hold `reset_n`=0 -> all `hex`=7'b1000001, all other outputs 0.
- **Acquire.** Raise `locked_in[0]` before edge 1 -> `hex[6:0]`="A" after edge 3; `stable[0]`=1 and "L" after edge 7; channel 1 remains "U" and `all_stable`=0.
- **Aborted settle.** Raise `locked_in[1]`, then drop it after 2 cycles of SETTLING -> channel 1 returns to "U", `loss_count[1]`=0, `lost_sticky[1]`=0.
- **Loss counting and saturation.** CNT_W=2; lock channel 0, then drop it 5 times -> `loss_count[0]` reads 1, 2, 3, 3, 3; `lost_sticky[0]`=1.
- **Clear with simultaneous loss.** Pulse `clear_sticky` on the same edge channel 0 leaves LOCKED -> `loss_count[0]`=1, `lost_sticky[0]`=1. A separate clear pulse with no loss -> both 0.
- **Reset mid-settle.** Assert `reset_n` low while channel 0 is in SETTLING with timer=2 -> immediately "U" and `stable`=0. After release with `locked_in` still high, `stable` again needs the full SYNC_STAGES+1+SETTLE_CYCLES edges.
